// File: rtl/card_shoe.sv
// Multi-deck card shoe: fills NUM_DECKS decks, shuffles them with an LFSR-driven
// Fisher-Yates pass, then deals cards without replacement.
module card_shoe #(
  parameter int          NUM_DECKS      = 1,
  parameter int          ADDR_W         = 9,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          LOW_MARK       = 10,
  parameter bit          AUTO_RESHUFFLE = 1'b0,
  localparam int         N              = 52 * NUM_DECKS,
  localparam int         CW             = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              draw_card,
  input  logic              shuffle,
  output logic [ADDR_W-1:0] rom_address,
  output logic [3:0]        card_rank,
  output logic [1:0]        card_suit,
  output logic [3:0]        card_value,
  output logic              card_valid,
  output logic              draw_error,
  output logic              busy,
  output logic [CW-1:0]     cards_left,
  output logic              low_shoe,
  output logic              empty
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {INIT, SHUFFLE, READY} state_e;

  state_e        state_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [IW-1:0] i_q, j;
  logic [5:0]    id_q;
  logic [CW-1:0] top_q, left_q;
  logic [5:0]    shoe_q [N];
  logic [IW+15:0] prod;
  logic [5:0]    top_id, suit_base, addr_q;
  logic [1:0]    top_suit, suit_q;
  logic [3:0]    top_rank, top_value, rank_q, value_q;
  logic          valid_q, err_q, busy_q;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // j = floor(lfsr * (i+1) / 2^16) always lands in 0..i
    prod   = {{IW{1'b0}}, lfsr_q} * {16'h0000, i_q + IW'(1)};
    j      = prod[IW+15:16];
    top_id = shoe_q[top_q[IW-1:0]];
    if (top_id >= 6'd39)      begin top_suit = 2'd3; suit_base = 6'd39; end
    else if (top_id >= 6'd26) begin top_suit = 2'd2; suit_base = 6'd26; end
    else if (top_id >= 6'd13) begin top_suit = 2'd1; suit_base = 6'd13; end
    else                      begin top_suit = 2'd0; suit_base = 6'd0;  end
    top_rank  = 4'(top_id - suit_base) + 4'd1;
    top_value = (top_rank > 4'd10) ? 4'd10 : top_rank;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      lfsr_q  <= LFSR_SEED;
      i_q     <= '0;
      id_q    <= '0;
      top_q   <= '0;
      left_q  <= '0;
      addr_q  <= '0;
      rank_q  <= '0;
      suit_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        INIT: begin
          shoe_q[i_q] <= id_q;
          id_q        <= (id_q == 6'd51) ? 6'd0 : id_q + 6'd1;
          if (i_q == IW'(N - 1)) state_q <= SHUFFLE;
          else                   i_q     <= i_q + IW'(1);
        end
        SHUFFLE: begin
          shoe_q[i_q] <= shoe_q[j];
          shoe_q[j]   <= shoe_q[i_q];
          if (i_q == IW'(1)) begin
            state_q <= READY;
            busy_q  <= 1'b0;
            top_q   <= '0;
            left_q  <= CW'(N);
          end else begin
            i_q <= i_q - IW'(1);
          end
        end
        READY: begin
          // shuffle wins over draw; an exhausted shoe auto-refills when enabled
          if (shuffle || (AUTO_RESHUFFLE && left_q == '0)) begin
            state_q <= INIT;
            busy_q  <= 1'b1;
            i_q     <= '0;
            id_q    <= '0;
            top_q   <= '0;
            left_q  <= '0;
          end else if (draw_card) begin
            if (left_q != '0) begin
              addr_q  <= top_id;
              rank_q  <= top_rank;
              suit_q  <= top_suit;
              value_q <= top_value;
              valid_q <= 1'b1;
              top_q   <= top_q + CW'(1);
              left_q  <= left_q - CW'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rom_address = ADDR_W'(addr_q);
  assign card_rank   = rank_q;
  assign card_suit   = suit_q;
  assign card_value  = value_q;
  assign card_valid  = valid_q;
  assign draw_error  = err_q;
  assign busy        = busy_q;
  assign cards_left  = left_q;
  assign low_shoe    = (state_q == READY) && (int'(left_q) <= LOW_MARK);
  assign empty       = (state_q == READY) && (left_q == '0) && !AUTO_RESHUFFLE;
endmodule
